// File: rtl/multicycle_ctrl.sv
// Five-state multicycle control unit for an RV32I subset: latches the fetched
// instruction, decodes ALU op / immediate / strobes, and resolves BEQ from the ALU zero flag.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        load_pc,
  output logic        pc_src
);

  localparam logic [3:0] ALUOP_AND                = 4'b0000;
  localparam logic [3:0] ALUOP_OR                 = 4'b0001;
  localparam logic [3:0] ALUOP_ADD                = 4'b0010;
  localparam logic [3:0] ALUOP_SUB                = 4'b0110;
  localparam logic [3:0] ALUOP_LESS               = 4'b0111;
  localparam logic [3:0] ALUOP_SHIFT_RIGHT        = 4'b1000;
  localparam logic [3:0] ALUOP_SHIFT_LEFT         = 4'b1001;
  localparam logic [3:0] ALUOP_SHIFT_RIGHT_ARITHM = 4'b1010;
  localparam logic [3:0] ALUOP_XOR                = 4'b1101;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] ir;
  logic        zero_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_r;
  logic        is_i;
  logic        is_lw;
  logic        is_sw;
  logic        is_beq;
  logic        r_legal;
  logic        i_legal;
  logic        alt_ok;
  logic        shamt_ok;
  logic        wb_en;
  logic        in_exec;
  logic [3:0]  alu_ir;
  logic        src_ir;

  // funct3 -> ALU op; sub_sel only ever set for R-type, sra_sel for srl/sra/srai
  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3,
                                               input logic sub_sel,
                                               input logic sra_sel);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub_sel ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  op = ALUOP_SHIFT_LEFT;
      3'b010:  op = ALUOP_LESS;
      3'b100:  op = ALUOP_XOR;
      3'b101:  op = sra_sel ? ALUOP_SHIFT_RIGHT_ARITHM : ALUOP_SHIFT_RIGHT;
      3'b110:  op = ALUOP_OR;
      3'b111:  op = ALUOP_AND;
      default: op = ALUOP_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IF;
      ir     <= 32'h0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IF) ir <= instr;
      if (state == S_EX) zero_q <= zero;
    end
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:    state_nxt = S_ID;
      S_ID:    state_nxt = S_EX;
      S_EX:    state_nxt = S_MEM;
      S_MEM:   state_nxt = S_WB;
      default: state_nxt = S_IF;
    endcase
  end

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);

  // funct7 0x20 selects sub/sra only; sltu/sltiu (funct3 011) are not supported
  assign alt_ok   = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign shamt_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                    (funct3 == 3'b101) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) : 1'b1;
  assign r_legal  = is_r && alt_ok && (funct3 != 3'b011);
  assign i_legal  = is_i && shamt_ok && (funct3 != 3'b011);
  assign wb_en    = (r_legal || i_legal || is_lw) && (rd != 5'd0);

  always_comb begin
    alu_ir = ALUOP_ADD;
    src_ir = 1'b0;
    imm    = 32'h0;
    if (r_legal) begin
      alu_ir = alu_of_funct3(funct3, funct7[5], funct7[5]);
    end else if (i_legal) begin
      alu_ir = alu_of_funct3(funct3, 1'b0, funct7[5]);
      src_ir = 1'b1;
      imm    = {{20{ir[31]}}, ir[31:20]};
    end else if (is_lw) begin
      src_ir = 1'b1;
      imm    = {{20{ir[31]}}, ir[31:20]};
    end else if (is_sw) begin
      src_ir = 1'b1;
      imm    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    end else if (is_beq) begin
      alu_ir = ALUOP_SUB;
      imm    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    end
  end

  // Reset overrides every control output so an aborted instruction writes nothing
  assign in_exec    = !rst && (state != S_IF);
  assign alu_op     = in_exec ? alu_ir : ALUOP_ADD;
  assign alu_src    = in_exec && src_ir;
  assign mem_read   = !rst && (state == S_MEM) && is_lw;
  assign mem_write  = !rst && (state == S_MEM) && is_sw;
  assign reg_write  = !rst && (state == S_WB) && wb_en;
  assign mem_to_reg = !rst && (state == S_WB) && is_lw;
  assign load_pc    = !rst && (state == S_WB);
  assign pc_src     = !rst && (state == S_WB) && is_beq && zero_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions through all five states
// and compares captured per-state outputs against hand-computed values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        mem_read, mem_write, reg_write, mem_to_reg, load_pc, pc_src;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  c_op  [5];
  logic        c_src [5];
  logic [31:0] c_imm [5];
  logic [4:0]  c_rd  [5];
  logic        c_mr  [5];
  logic        c_mw  [5];
  logic        c_rw  [5];
  logic        c_m2r [5];
  logic        c_lpc [5];
  logic        c_pcs [5];

  logic mon_en  = 1'b0;
  logic mw_seen = 1'b0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .alu_op(alu_op), .alu_src(alu_src), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .load_pc(load_pc), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && mem_write) mw_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input int k);
    c_op[k]  = alu_op;     c_src[k] = alu_src;   c_imm[k] = imm;     c_rd[k] = rd;
    c_mr[k]  = mem_read;   c_mw[k]  = mem_write; c_rw[k]  = reg_write;
    c_m2r[k] = mem_to_reg; c_lpc[k] = load_pc;   c_pcs[k] = pc_src;
  endtask

  // Called at a falling edge in IF; returns at the falling edge of the next IF.
  // zero carries z_ex only during EX and z_other in every other state.
  task automatic exec(input logic [31:0] i, input logic z_ex, input logic z_other);
    instr = i;
    zero  = z_other;
    cap(0);
    @(negedge clk); cap(1); instr = 32'hFFFF_FFFF;
    @(negedge clk); cap(2); zero = z_ex;
    @(negedge clk); cap(3); zero = z_other;
    @(negedge clk); cap(4);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_pc", load_pc, 0);
    chk("rst_reg_write", reg_write, 0);
    rst = 1'b0;
    chk("reset_alu_op", alu_op, 4'b0010);
    chk("reset_alu_src", alu_src, 0);
    chk("reset_imm", imm, 0);
    chk("reset_fields", {rs1, rs2, rd}, 0);
    chk("reset_strobes", {mem_read, mem_write, reg_write, load_pc, pc_src, mem_to_reg}, 0);

    // add x3,x1,x2
    exec(32'h002081B3, 1'b0, 1'b0);
    chk("add_ex_op", c_op[2], 4'b0010);
    chk("add_ex_src", c_src[2], 0);
    chk("add_if_op", c_op[0], 4'b0010);
    chk("add_mem_strobes", {c_mr[3], c_mw[3], c_rw[3], c_lpc[3]}, 0);
    chk("add_wb_rw", c_rw[4], 1);
    chk("add_wb_rd", c_rd[4], 3);
    chk("add_wb_lpc", c_lpc[4], 1);
    chk("add_wb_pcs", c_pcs[4], 0);
    chk("add_id_rw", c_rw[1], 0);

    // sra x5,x6,x7
    exec(32'h407352B3, 1'b0, 1'b0);
    chk("sra_id_op", c_op[1], 4'b1010);
    chk("sra_wb_op", c_op[4], 4'b1010);
    chk("sra_wb_rw", c_rw[4], 1);

    // srai x5,x6,3 with imm[11:5]=0x10 is illegal
    exec(32'h20335293, 1'b0, 1'b0);
    chk("after_sra_if_op", c_op[0], 4'b0010);
    chk("srai_bad_rw", c_rw[4], 0);
    chk("srai_bad_lpc", c_lpc[4], 1);
    chk("srai_bad_pcs", c_pcs[4], 0);
    chk("srai_bad_imm", c_imm[2], 0);
    chk("srai_bad_mem", {c_mr[3], c_mw[3]}, 0);

    // legal srai x5,x6,3 (imm[11:5]=0x20)
    exec(32'h40335293, 1'b0, 1'b0);
    chk("srai_op", c_op[2], 4'b1010);
    chk("srai_src", c_src[2], 1);
    chk("srai_imm", c_imm[2], 32'h403);
    chk("srai_rw", c_rw[4], 1);

    // lw x4,-4(x2)
    exec(32'hFFC12203, 1'b0, 1'b0);
    chk("lw_imm", c_imm[2], 32'hFFFF_FFFC);
    chk("lw_src", c_src[2], 1);
    chk("lw_op", c_op[2], 4'b0010);
    chk("lw_mem_read", c_mr[3], 1);
    chk("lw_ex_mem_read", c_mr[2], 0);
    chk("lw_wb_m2r", c_m2r[4], 1);
    chk("lw_wb_rw", c_rw[4], 1);
    chk("lw_mem_m2r", c_m2r[3], 0);

    // beq x1,x2,+8 taken
    exec(32'h00208463, 1'b1, 1'b0);
    chk("after_lw_if_src", c_src[0], 0);
    chk("beq_imm", c_imm[2], 8);
    chk("beq_op", c_op[2], 4'b0110);
    chk("beq_t_pcs", c_pcs[4], 1);
    chk("beq_t_mem_pcs", c_pcs[3], 0);
    chk("beq_rw", c_rw[4], 0);

    // beq not taken, zero high outside EX
    exec(32'h00208463, 1'b0, 1'b1);
    chk("beq_nt_pcs", c_pcs[4], 0);
    chk("beq_nt_lpc", c_lpc[4], 1);

    // sw x2,8(x1)
    exec(32'h0020A423, 1'b0, 1'b0);
    chk("sw_imm", c_imm[2], 8);
    chk("sw_src", c_src[2], 1);
    chk("sw_mem_write", c_mw[3], 1);
    chk("sw_wb_rw", c_rw[4], 0);
    chk("sw_wb_mw", c_mw[4], 0);

    // sltu is illegal; add to x0 must not write
    exec(32'h003130B3, 1'b0, 1'b0);
    chk("sltu_rw", c_rw[4], 0);
    chk("sltu_lpc", c_lpc[4], 1);
    exec(32'h00208033, 1'b0, 1'b0);
    chk("add_x0_rw", c_rw[4], 0);

    // reset held two cycles starting mid-EX of a SW
    mon_en  = 1'b1;
    mw_seen = 1'b0;
    instr   = 32'h0020A423;
    @(negedge clk); instr = 32'hFFFF_FFFF;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mw", mem_write, 0);
    chk("rst_mid_lpc", load_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_alu_op", alu_op, 4'b0010);
    chk("rst_mid_rd", rd, 0);
    chk("rst_mid_imm", imm, 0);
    exec(32'h002081B3, 1'b0, 1'b0);
    chk("post_rst_id_rd", c_rd[1], 3);
    chk("post_rst_ex_op", c_op[2], 4'b0010);
    chk("post_rst_wb_rw", c_rw[4], 1);
    mon_en = 1'b0;
    chk("rst_sw_no_write", mw_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
